// File: rtl/serial7_tx.sv
// Serial transmitter for the 7-bit word path: valid/ready word in, async frame out
// (start, 7 data bits LSB first, optional parity, one stop bit), internally timed.
module serial7_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [6:0] d,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  // Only reached when CLKS_PER_BIT >= 2; done is raised one edge early so it
  // lines up with the final stop cycle.
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          par;

  // Outputs are set on the edge that enters each state, so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            state <= START;
            div   <= '0;
            shreg <= d;
            par   <= (^d) ^ PARITY_ODD;
            tx    <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: begin
          if (div == DIV_LAST) begin
            div <= '0;
            case (state)
              START: begin
                state   <= DATA;
                tx      <= shreg[0];
                bit_cnt <= '0;
              end
              DATA: begin
                shreg <= shreg >> 1;
                if (bit_cnt == 3'd6) begin
                  bit_cnt <= '0;
                  if (PARITY_EN) begin
                    state <= PARITY;
                    tx    <= par;
                  end else begin
                    state <= STOP;
                    tx    <= 1'b1;
                    done  <= (CLKS_PER_BIT == 1);
                  end
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  tx      <= shreg[1];
                end
              end
              PARITY: begin
                state <= STOP;
                tx    <= 1'b1;
                done  <= (CLKS_PER_BIT == 1);
              end
              STOP: begin
                state <= IDLE;
                ready <= 1'b1;
                busy  <= 1'b0;
              end
              default: begin
                state <= IDLE;
                tx    <= 1'b1;
                ready <= 1'b1;
                busy  <= 1'b0;
              end
            endcase
          end else begin
            div <= div + 1'b1;
            if (state == STOP && div == DIV_PRE) done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
